// File: rtl/core_biu_arb_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the single memory port.
// The arbiter uses the master view; the requesters and the memory model use the slave view.
interface core_biu_arb_if #(
  parameter int CORE_XLEN            = 32,
  parameter int CORE_LSU_WMASK_WIDTH = 4
);
  logic                            ifu_req_valid;
  logic                            ifu_req_ready;
  logic [CORE_XLEN-1:0]            ifu_req_addr;
  logic                            ifu_rsp_valid;
  logic [CORE_XLEN-1:0]            ifu_rsp_data;

  logic                            lsu_req_valid;
  logic                            lsu_req_ready;
  logic [CORE_XLEN-1:0]            lsu_req_addr;
  logic                            lsu_req_wen;
  logic [CORE_XLEN-1:0]            lsu_req_wdata;
  logic [CORE_LSU_WMASK_WIDTH-1:0] lsu_req_wmask;
  logic                            lsu_rsp_valid;
  logic [CORE_XLEN-1:0]            lsu_rsp_rdata;

  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic [CORE_XLEN-1:0]            mem_addr;
  logic                            mem_wen;
  logic [CORE_XLEN-1:0]            mem_wdata;
  logic [CORE_LSU_WMASK_WIDTH-1:0] mem_wmask;
  logic                            mem_rsp_valid;
  logic [CORE_XLEN-1:0]            mem_rsp_rdata;

  modport master (
    input  ifu_req_valid, ifu_req_addr,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/core_biu_arb.sv
// IFU/LSU arbiter in front of the single memory port: one outstanding transaction,
// LSU priority with a starvation counter for the IFU, and stale-fetch dropping on flush.
module core_biu_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_pipe_flush_req,
  output logic           arb_busy,
  core_biu_arb_if.master bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, WAIT_IFU, WAIT_LSU} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             drop_q, drop_d;
  logic             ifu_eff, lsu_win, ifu_win;

  // A flush masks the IFU request in the very cycle it is raised.
  assign ifu_eff = bus.ifu_req_valid & ~i_pipe_flush_req;
  assign lsu_win = bus.lsu_req_valid & (~ifu_eff | (starve_cnt_q < CNT_MAX));
  assign ifu_win = ~lsu_win & ifu_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    starve_cnt_d      = starve_cnt_q;
    drop_d            = drop_q;
    arb_busy          = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_wdata     = '0;
    bus.mem_wmask     = '0;
    bus.ifu_req_ready = 1'b0;
    bus.lsu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rsp_rdata = '0;

    case (state_q)
      IDLE: begin
        if (!bus.ifu_req_valid) starve_cnt_d = '0;
        if (lsu_win) begin
          bus.mem_req_valid = 1'b1;
          bus.mem_addr      = bus.lsu_req_addr;
          bus.mem_wen       = bus.lsu_req_wen;
          bus.mem_wdata     = bus.lsu_req_wdata;
          bus.mem_wmask     = bus.lsu_req_wmask;
          bus.lsu_req_ready = bus.mem_req_ready;
          if (bus.mem_req_ready) begin
            state_d = WAIT_LSU;
            if (ifu_eff && (starve_cnt_q != CNT_MAX)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (ifu_win) begin
          bus.mem_req_valid = 1'b1;
          bus.mem_addr      = bus.ifu_req_addr;
          bus.ifu_req_ready = bus.mem_req_ready;
          if (bus.mem_req_ready) begin
            state_d      = WAIT_IFU;
            starve_cnt_d = '0;
            drop_d       = i_pipe_flush_req;
          end
        end
      end
      WAIT_IFU: begin
        arb_busy = 1'b1;
        if (i_pipe_flush_req) drop_d = 1'b1;
        if (bus.mem_rsp_valid) begin
          bus.ifu_rsp_valid = ~(drop_q | i_pipe_flush_req);
          bus.ifu_rsp_data  = bus.ifu_rsp_valid ? bus.mem_rsp_rdata : '0;
          state_d           = IDLE;
          drop_d            = 1'b0;
        end
      end
      WAIT_LSU: begin
        arb_busy = 1'b1;
        if (bus.mem_rsp_valid) begin
          bus.lsu_rsp_valid = 1'b1;
          bus.lsu_rsp_rdata = bus.mem_rsp_rdata;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_core_biu_arb.sv
// Self-checking bench for core_biu_arb: a vector table for the IDLE grant logic plus
// hand-written multi-cycle sequences, with a response scoreboard checked by a monitor.
module tb_core_biu_arb;
  logic clk;
  logic rst_n;
  logic i_pipe_flush_req;
  logic arb_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        to_ifu;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic        lsu_wen;
    logic        flush;
    logic        mem_rdy;
    logic [1:0]  exp_win;
    logic        exp_ifu_rdy;
    logic        exp_lsu_rdy;
    logic        exp_mem_v;
    logic        exp_wen;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[9];

  core_biu_arb_if #(.CORE_XLEN(32), .CORE_LSU_WMASK_WIDTH(4)) bus ();

  core_biu_arb #(.STARVE_MAX(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_pipe_flush_req (i_pipe_flush_req),
    .arb_busy         (arb_busy),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value against the bench's expectation.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drop_requests();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    i_pipe_flush_req  = 1'b0;
  endtask

  // Drives a memory response for one cycle; the expected delivery goes to the scoreboard.
  task automatic respond(input logic [31:0] d, input logic to_ifu, input logic deliver);
    rsp_t e;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = d;
    if (deliver) begin
      e.to_ifu = to_ifu;
      e.data   = d;
      exp_q.push_back(e);
    end
    #2;
    if (!deliver) check("drop_no_pulse", {31'b0, bus.ifu_rsp_valid}, 32'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
  endtask

  // Every response pulse must match the head of the scoreboard.
  always begin
    rsp_t e;
    @(negedge clk);
    #3;
    if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_rsp: got ifu=%b lsu=%b want no pulse",
                 bus.ifu_rsp_valid, bus.lsu_rsp_valid);
      end else begin
        e = exp_q.pop_front();
        check("rsp_ifu_valid", {31'b0, bus.ifu_rsp_valid}, {31'b0, e.to_ifu});
        check("rsp_lsu_valid", {31'b0, bus.lsu_rsp_valid}, {31'b0, ~e.to_ifu});
        check("rsp_data", e.to_ifu ? bus.ifu_rsp_data : bus.lsu_rsp_rdata, e.data);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    bus.ifu_req_valid = v.ifu_v;
    bus.ifu_req_addr  = 32'h0000_0040;
    bus.lsu_req_valid = v.lsu_v;
    bus.lsu_req_addr  = 32'h0000_0080;
    bus.lsu_req_wen   = v.lsu_wen;
    bus.lsu_req_wdata = 32'h55AA_55AA;
    bus.lsu_req_wmask = 4'h3;
    bus.mem_req_ready = v.mem_rdy;
    i_pipe_flush_req  = v.flush;
  endtask

  task automatic checkOutput(input vec_t v);
    check("vec_ifu_ready", {31'b0, bus.ifu_req_ready}, {31'b0, v.exp_ifu_rdy});
    check("vec_lsu_ready", {31'b0, bus.lsu_req_ready}, {31'b0, v.exp_lsu_rdy});
    check("vec_mem_valid", {31'b0, bus.mem_req_valid}, {31'b0, v.exp_mem_v});
    check("vec_mem_wen",   {31'b0, bus.mem_wen},       {31'b0, v.exp_wen});
    check("vec_mem_addr",  bus.mem_addr, v.exp_addr);
    check("vec_mem_wdata", bus.mem_wdata, (v.exp_win == 2'd2) ? 32'h55AA_55AA : 32'd0);
    check("vec_mem_wmask", {28'b0, bus.mem_wmask}, (v.exp_win == 2'd2) ? 32'd3 : 32'd0);
    check("vec_busy",      {31'b0, arb_busy}, 32'd0);
    check("vec_rsp_zero",  bus.ifu_rsp_data | bus.lsu_rsp_rdata, 32'd0);
  endtask

  initial begin
    logic        exp_order[7];
    logic [31:0] exp_starve[7];

    exp_order  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_starve = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};

    //            ifu lsu wen fl rdy win  irdy lrdy mv  wen  addr
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80};

    rst_n             = 1'b0;
    bus.ifu_req_addr  = '0;
    bus.lsu_req_addr  = '0;
    bus.lsu_req_wdata = '0;
    bus.lsu_req_wmask = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    drop_requests();

    // Reset state: everything quiet, counters cleared.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_busy",      {31'b0, arb_busy}, 32'd0);
    check("rst_mem_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    check("rst_readies",   {30'b0, bus.ifu_req_ready, bus.lsu_req_ready}, 32'd0);
    check("rst_rsp",       {30'b0, bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 32'd0);
    check("rst_starve",    {29'b0, dut.starve_cnt_q}, 32'd0);
    check("rst_drop",      {31'b0, dut.drop_q}, 32'd0);
    @(negedge clk);

    // IDLE grant table; handshakes are completed with a one-cycle response.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i]);
      @(negedge clk);
      drop_requests();
      bus.mem_req_ready = 1'b1;
      if (vecs[i].exp_mem_v && vecs[i].mem_rdy)
        respond(32'hA000_0000 + 32'(i), vecs[i].exp_ifu_rdy, 1'b1);
    end
    @(negedge clk);

    // IFU-only fetch, response two cycles after the request.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0000;
    #2;
    check("t1_ifu_ready", {31'b0, bus.ifu_req_ready}, 32'd1);
    check("t1_mem_addr",  bus.mem_addr, 32'h8000_0000);
    check("t1_busy0",     {31'b0, arb_busy}, 32'd0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    #2;
    check("t1_busy1", {31'b0, arb_busy}, 32'd1);
    check("t1_no_req_in_wait", {31'b0, bus.mem_req_valid}, 32'd0);
    @(negedge clk);
    check("t1_busy2", {31'b0, arb_busy}, 32'd1);
    respond(32'h0000_0013, 1'b1, 1'b1);
    #2;
    check("t1_busy3", {31'b0, arb_busy}, 32'd0);
    @(negedge clk);

    // Simultaneous IFU fetch and LSU store: LSU first, IFU right after.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0200;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0100;
    bus.lsu_req_wdata = 32'hDEAD_BEEF;
    bus.lsu_req_wmask = 4'hF;
    #2;
    check("t2_lsu_ready", {31'b0, bus.lsu_req_ready}, 32'd1);
    check("t2_ifu_ready", {31'b0, bus.ifu_req_ready}, 32'd0);
    check("t2_mem_wen",   {31'b0, bus.mem_wen}, 32'd1);
    check("t2_mem_wmask", {28'b0, bus.mem_wmask}, 32'hF);
    check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.lsu_req_wen   = 1'b0;
    respond(32'd0, 1'b0, 1'b1);
    #2;
    check("t2_ifu_next_ready", {31'b0, bus.ifu_req_ready}, 32'd1);
    check("t2_ifu_next_addr",  bus.mem_addr, 32'h0000_0200);
    check("t2_ifu_wmask_zero", {28'b0, bus.mem_wmask}, 32'd0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    respond(32'h1111_1111, 1'b1, 1'b1);
    @(negedge clk);

    // Starvation: IFU pending while the LSU streams loads.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0400;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_addr  = 32'h0000_0800;
    for (int k = 0; k < 7; k++) begin
      #2;
      check("t3_starve_cnt", {29'b0, dut.starve_cnt_q}, exp_starve[k]);
      check("t3_ifu_grant",  {31'b0, bus.ifu_req_ready}, {31'b0, exp_order[k]});
      check("t3_lsu_grant",  {31'b0, bus.lsu_req_ready}, {31'b0, ~exp_order[k]});
      check("t3_mem_addr",   bus.mem_addr, exp_order[k] ? 32'h0000_0400 : 32'h0000_0800);
      @(negedge clk);
      if (k == 6) drop_requests();
      respond(32'h0000_00C0 + 32'(k), exp_order[k], 1'b1);
    end
    @(negedge clk);

    // Flush one cycle after the IFU handshake: response is dropped.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0300;
    #2;
    check("t4_ifu_ready", {31'b0, bus.ifu_req_ready}, 32'd1);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    i_pipe_flush_req  = 1'b1;
    @(negedge clk);
    i_pipe_flush_req  = 1'b0;
    repeat (2) @(negedge clk);
    respond(32'h0000_0BAD, 1'b1, 1'b0);
    #2;
    check("t4_idle_after_drop", {31'b0, arb_busy}, 32'd0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0304;
    #2;
    check("t4_refetch_ready", {31'b0, bus.ifu_req_ready}, 32'd1);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    respond(32'h0000_600D, 1'b1, 1'b1);
    @(negedge clk);

    // Flush coincident with the IFU response: dropped.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0500;
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    i_pipe_flush_req  = 1'b1;
    respond(32'h0000_0DED, 1'b1, 1'b0);
    i_pipe_flush_req  = 1'b0;
    @(negedge clk);

    // Flush during WAIT_LSU: the load still completes.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0600;
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    i_pipe_flush_req  = 1'b1;
    @(negedge clk);
    i_pipe_flush_req  = 1'b0;
    respond(32'h0000_CAFE, 1'b0, 1'b1);
    @(negedge clk);

    // Reset in WAIT_LSU: outputs drop at once and the late response is ignored.
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0700;
    #2;
    check("t6_lsu_ready", {31'b0, bus.lsu_req_ready}, 32'd1);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    #2;
    check("t6_busy_before", {31'b0, arb_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_async", {31'b0, arb_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h0000_1A7E;
    #2;
    check("t6_late_rsp", {31'b0, bus.lsu_rsp_valid}, 32'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0704;
    #2;
    check("t6_regrant", {31'b0, bus.lsu_req_ready}, 32'd1);
    @(negedge clk);
    drop_requests();
    respond(32'd0, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    #5;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_biu_arb.md
# core_biu_arb

Two-port to one-port memory arbiter between the instruction fetch unit (IFU) and the load/store unit (LSU), sitting in front of the single `biu_pmem` data port of `core_cpu`. It accepts at most one outstanding transaction, favours the LSU, and guarantees IFU forward progress with a starvation counter. It also discards a stale fetch response when the pipeline is flushed mid-fetch.

## Interface
- `STARVE_MAX`, default 4: the IFU is forced a grant after this many consecutive LSU grants taken while an IFU request was pending. Legal range 1..15.
- `clk` input, 1: clock; all state is rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `ifu_req_valid` input, 1: IFU fetch request.
- `ifu_req_ready` output, 1: IFU request accepted this cycle.
- `ifu_req_addr` input, `CORE_XLEN`: fetch address.
- `ifu_rsp_valid` output, 1: fetch data valid (one-cycle pulse).
- `ifu_rsp_data` output, `CORE_XLEN`: fetched word.
- `lsu_req_valid` input, 1: LSU load/store request.
- `lsu_req_ready` output, 1: LSU request accepted.
- `lsu_req_addr` input, `CORE_XLEN`: data address.
- `lsu_req_wen` input, 1: 1 = store, 0 = load.
- `lsu_req_wdata` input, `CORE_XLEN`: store data.
- `lsu_req_wmask` input, `CORE_LSU_WMASK_WIDTH`: byte mask.
- `lsu_rsp_valid` output, 1: load data or store acknowledge (one-cycle pulse).
- `lsu_rsp_rdata` output, `CORE_XLEN`: load data.
- `i_pipe_flush_req` input, 1: pipeline flush from commit.
- `mem_req_valid` output, 1: request to memory.
- `mem_req_ready` input, 1: memory accepts the request.
- `mem_addr` output, `CORE_XLEN`.
- `mem_wen` output, 1.
- `mem_wdata` output, `CORE_XLEN`.
- `mem_wmask` output, `CORE_LSU_WMASK_WIDTH`.
- `mem_rsp_valid` input, 1: memory response.
- `mem_rsp_rdata` input, `CORE_XLEN`: memory response data.
- `arb_busy` output, 1: a transaction is outstanding.

## Operation
- The FSM has three states: `IDLE`, `WAIT_IFU`, `WAIT_LSU`. Reset state is `IDLE`.
- `IDLE` grant selection:
  - `ifu_eff = ifu_req_valid & ~i_pipe_flush_req`.
  - If `lsu_req_valid` and (`~ifu_eff` or `starve_cnt < STARVE_MAX`), the LSU wins.
  - Otherwise, if `ifu_eff`, the IFU wins.
- `IDLE` outputs:
  - `mem_req_valid` = the winner's valid.
  - `mem_*` fields are muxed from the winner.
  - For IFU requests, `mem_wen=0`, `mem_wmask=0`, `mem_wdata=0`.
  - The winner's `*_req_ready = mem_req_ready`. The loser's ready = 0.
- On handshake (`mem_req_valid & mem_req_ready`), go to `WAIT_LSU` or `WAIT_IFU` according to the winner.
- In `WAIT_*` states: `mem_req_valid=0`, both `*_req_ready=0`, `arb_busy=1`.
- `WAIT_LSU` + `mem_rsp_valid`: `lsu_rsp_valid=1`, `lsu_rsp_rdata=mem_rsp_rdata`, go to `IDLE`.
- `WAIT_IFU` + `mem_rsp_valid`: `ifu_rsp_valid = ~drop`, `ifu_rsp_data=mem_rsp_rdata`, go to `IDLE`, clear `drop`.
- `drop` flag:
  - Set when `i_pipe_flush_req=1` while in `WAIT_IFU`.
  - Also set in the IFU handshake cycle if flush is high (unreachable because flush masks `ifu_eff`; kept for safety).
  - If flush and `mem_rsp_valid` coincide in `WAIT_IFU`, the response is dropped.
  - A flush in `WAIT_LSU` has no effect; stores and loads always complete.
- `starve_cnt`:
  - Width `$clog2(STARVE_MAX+1)`.
  - Increments (saturating at `STARVE_MAX`) on an LSU handshake while `ifu_eff=1`.
  - Clears on an IFU handshake.
  - Clears in any `IDLE` cycle with `ifu_req_valid=0`.
  - Holds otherwise.
- `mem_rsp_valid` in `IDLE` is ignored: no response pulse and no state change.
- Response data outputs are 0 whenever the corresponding `*_rsp_valid` is 0.

## Timing
- Reset values: state `IDLE`, `starve_cnt=0`, `drop=0`. With no requests, all outputs are 0.
- Request paths are combinational from inputs to `mem_*` and `*_req_ready` in `IDLE`. No registered request stage.
- Response pass-through is combinational, same cycle as `mem_rsp_valid`.
- The earliest response is the cycle after the handshake. The earliest next request is the cycle after the response.
- Minimum 2 cycles per transaction with zero-latency memory.
- The requester must hold valid and fields stable until ready. Requests are never cancelled by the arbiter, except that flush masks the IFU in the same cycle.
- Reset asserted mid-transaction returns to `IDLE` immediately. A late `mem_rsp_valid` after reset is ignored.
- Requesters must always accept responses (no response backpressure).

## Test plan
- IFU only, addr 0x8000_0000, memory ready immediately, rsp 2 cycles later with 0x0000_0013:
  - `ifu_req_ready` high in cycle 0.
  - `ifu_rsp_valid` pulses once with 0x13.
  - `arb_busy` high cycles 1–2.
- Simultaneous IFU and LSU store (addr 0x100, wdata 0xDEADBEEF, mask 0xF):
  - LSU granted first with `mem_wen=1` and `mem_wmask=0xF`.
  - IFU granted in the first `IDLE` cycle after the LSU response.
- Starvation, `STARVE_MAX=4`: IFU valid continuously while the LSU issues 6 back-to-back loads.
  - Grant order is L,L,L,L,I,L,…
  - `starve_cnt` reads 4 before the IFU grant and 0 after it.
- Flush during `WAIT_IFU` (flush pulse 1 cycle after the handshake, rsp 3 cycles later):
  - No `ifu_rsp_valid` pulse.
  - FSM returns to `IDLE`.
  - The next IFU fetch returns data normally.
- Flush coincident with `mem_rsp_valid` in `WAIT_IFU`: response dropped. Flush during `WAIT_LSU`: `lsu_rsp_valid` still pulses.
- `rst_n` low during `WAIT_LSU`:
  - Outputs go to 0 asynchronously.
  - A `mem_rsp_valid` arriving after release produces no `lsu_rsp_valid`.
  - The next request is granted normally.
